// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the transmitter.
//   uart_state_e : receiver FSM state encoding
//   DefaultSize, DefaultOversample : default frame width and clocks per bit
//   StartBitVal, StopBitVal, IdleLineVal : serial line levels of the frame format
package uart_pkg;

  parameter int unsigned DefaultSize       = 32;
  parameter int unsigned DefaultOversample = 16;

  parameter logic StartBitVal = 1'b0;
  parameter logic StopBitVal  = 1'b1;
  parameter logic IdleLineVal = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received word and status out.
//   ReceivedSerialData : asynchronous serial line, idle high
//   DataOut            : last received data word (SIZE bits)
//   DataValid          : one-cycle pulse per completed frame
//   ParityErr/FrameErr : error flags of the last frame
//   BusyRx             : receiver is inside a frame or a break
// master : the receiver; slave : the line driver / data consumer.
interface uart_rx_if #(
  parameter int unsigned SIZE = uart_pkg::DefaultSize
);
  logic            ReceivedSerialData;
  logic [SIZE-1:0] DataOut;
  logic            DataValid;
  logic            ParityErr;
  logic            FrameErr;
  logic            BusyRx;

  modport master (
    input  ReceivedSerialData,
    output DataOut,
    output DataValid,
    output ParityErr,
    output FrameErr,
    output BusyRx
  );

  modport slave (
    output ReceivedSerialData,
    input  DataOut,
    input  DataValid,
    input  ParityErr,
    input  FrameErr,
    input  BusyRx
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk_i : sampling clock
//   rst_i : synchronous active-high reset; both flops go to the idle line level
//   d_i   : asynchronous input
//   q_o   : synchronized output
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= IdleLineVal;
      s2_q <= IdleLineVal;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, SIZE data bits LSB first, even parity, stop.
//   CLK_Baudin : clock at OVERSAMPLE x bit rate
//   RstRx      : synchronous active-high reset
//   bus        : uart_rx_if master (serial line in, data word and status out)
// DataValid pulses one cycle after the stop-bit midpoint sample, regardless of errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SIZE       = DefaultSize,
  parameter int unsigned OVERSAMPLE = DefaultOversample
) (
  input logic       CLK_Baudin,
  input logic       RstRx,
  uart_rx_if.master bus
);
  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(SIZE + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(SIZE - 1);

  logic line;

  uart_sync2 u_sync2 (
    .clk_i (CLK_Baudin),
    .rst_i (RstRx),
    .d_i   (bus.ReceivedSerialData),
    .q_o   (line)
  );

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SIZE-1:0] shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            stop_q, stop_d;
  logic            done_q, done_d;
  logic [SIZE-1:0] data_q;
  logic            valid_q, perr_q, ferr_q;

  logic mid_tick, bit_tick, busy;

  // State register
  always_ff @(posedge CLK_Baudin) begin
    if (RstRx) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (line == StartBitVal) state_d = StStart;
      StStart:  if (mid_tick) state_d = (line == StartBitVal) ? StData : StIdle;
      StData:   if (bit_tick && bit_cnt_q == LastBit) state_d = StParity;
      StParity: if (bit_tick) state_d = StStop;
      StStop:   if (bit_tick) state_d = (line == StopBitVal) ? StIdle : StBreak;
      StBreak:  if (line == IdleLineVal) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode: sample strobes and busy flag
  always_comb begin
    mid_tick = (state_q == StStart) && (cnt_q == HalfLast);
    bit_tick = (state_q inside {StData, StParity, StStop}) && (cnt_q == FullLast);
    busy     = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q + CntW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    // Counter restarts at every sample point so it never wraps inside a bit.
    if (state_q inside {StIdle, StBreak} || mid_tick || bit_tick) cnt_d = '0;
    if (state_q != StData) bit_cnt_d = '0;
    else if (bit_tick)     bit_cnt_d = bit_cnt_q + BitW'(1);
    if (bit_tick) begin
      unique case (state_q)
        StData:   shift_d = SIZE'({line, shift_q} >> 1);
        StParity: parity_d = line;
        StStop: begin
          stop_d = line;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_Baudin) begin
    if (RstRx) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
    end
  end

  // Results are published one cycle after the stop sample and held until the next frame.
  always_ff @(posedge CLK_Baudin) begin
    if (RstRx) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= done_q;
      if (done_q) begin
        data_q <= shift_q;
        perr_q <= parity_q ^ (^shift_q);
        ferr_q <= ~stop_q;
      end
    end
  end

  assign bus.DataOut   = data_q;
  assign bus.DataValid = valid_q;
  assign bus.ParityErr = perr_q;
  assign bus.FrameErr  = ferr_q;
  assign bus.BusyRx    = busy;
endmodule
